bram_window_sched: RTL and testbench



---
 rtl/bram_window_pkg.sv | 24 ++
 rtl/bram_bank_addr_gen.sv | 47 ++++
 rtl/bram_window_sched.sv | 148 ++++++++++++++
 tb/tb_bram_window_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_window_pkg.sv
// Shared constants, FSM state type and sizing helpers for the banked-BRAM window scheduler.
package bram_window_pkg;

    localparam int NBANK = 5;
    localparam int ROT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for a one-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Smallest per-bank address width able to hold ceil(rows/5) lines of cols pixels.
    function automatic int min_aw(input int rows, input int cols);
        return idx_w(((rows + NBANK - 1) / NBANK) * cols);
    endfunction

endpackage

// File: rtl/bram_bank_addr_gen.sv
// Per-bank line base registers and window rotation; base addresses advance by COLS
// incrementally so no multiplier is needed.
module bram_bank_addr_gen
    import bram_window_pkg::*;
#(
    parameter int COLS = 64,
    parameter int AW   = 10,
    parameter int CW   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_row_advance,
    input  logic [CW-1:0]      i_col,
    output logic [NBANK*AW-1:0] o_addr,
    output logic [ROT_W-1:0]   o_rot
);

    logic [AW-1:0]    r_base [NBANK];
    logic [ROT_W-1:0] r_rot;

    // Moving the window down one row retires the top row's bank to its next line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NBANK; k++) r_base[k] <= '0;
            r_rot <= '0;
        end else if (i_clear) begin
            for (int k = 0; k < NBANK; k++) r_base[k] <= '0;
            r_rot <= '0;
        end else if (i_row_advance) begin
            for (int k = 0; k < NBANK; k++) begin
                if (r_rot == ROT_W'(k)) r_base[k] <= r_base[k] + AW'(COLS);
            end
            r_rot <= (r_rot == ROT_W'(NBANK - 1)) ? '0 : r_rot + ROT_W'(1);
        end
    end

    always_comb begin
        o_addr = '0;
        for (int k = 0; k < NBANK; k++) begin
            o_addr[k*AW +: AW] = r_base[k] + AW'(i_col);
        end
    end

    assign o_rot = r_rot;

endmodule

// File: rtl/bram_window_sched.sv
// Frame scan controller: one 5-bank parallel read per vertical window, steer controls one cycle later.
// Optional stall_cycles counter enabled by defining BRAM_WINDOW_SCHED_STALL_CNT_EN.
// Handshake: a read issues in every READ cycle where out_ready=1; its sm_en follows one cycle later
// unconditionally, so the sink must absorb one window after dropping out_ready.
module bram_window_sched
    import bram_window_pkg::*;
#(
    parameter int COLS = 64,
    parameter int ROWS = 64,
    parameter int AW   = 10,
    localparam int RW  = idx_w(ROWS),
    localparam int CW  = idx_w(COLS)
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                start,
    input  logic                out_ready,
    output logic                busy,
    output logic                complete,
    output logic                bram_en,
    output logic [NBANK*AW-1:0] bram_addr,
    output logic                sm_en,
    output logic [ROT_W-1:0]    sm_rot,
    output logic [RW-1:0]       row_idx,
    output logic [CW-1:0]       col_idx,
`ifdef BRAM_WINDOW_SCHED_STALL_CNT_EN
    output logic [31:0]         stall_cycles,
`endif
    output logic [1:0]          dbg_state
);

    state_t           r_state;
    logic             r_armed;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic             r_busy;
    logic             r_complete;
    logic             r_sm_en;
    logic [ROT_W-1:0] r_sm_rot;
    logic [RW-1:0]    r_row_idx;
    logic [CW-1:0]    r_col_idx;

    logic             w_start_ok;
    logic             w_issue;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_row_adv;
    logic [ROT_W-1:0] w_rot;
    logic [NBANK*AW-1:0] w_addr;

    // r_armed keeps a start that overlaps reset release from launching a frame.
    assign w_start_ok = start && r_armed && ((r_state == IDLE) || (r_state == DONE));
    assign w_issue    = (r_state == READ) && out_ready;
    assign w_last_col = (r_col == CW'(COLS - 1));
    assign w_last_row = (r_row == RW'(ROWS - 5));
    // The final window does not advance the row, so rotation stays within the frame's range.
    assign w_row_adv  = w_issue && w_last_col && !w_last_row;

    bram_bank_addr_gen #(
        .COLS (COLS),
        .AW   (AW),
        .CW   (CW)
    ) u_addr_gen (
        .i_clk         (CLK),
        .i_rst_n       (rst_n),
        .i_clear       (w_start_ok),
        .i_row_advance (w_row_adv),
        .i_col         (r_col),
        .o_addr        (w_addr),
        .o_rot         (w_rot)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_armed    <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
            r_sm_en    <= 1'b0;
            r_sm_rot   <= '0;
            r_row_idx  <= '0;
            r_col_idx  <= '0;
        end else begin
            r_armed   <= 1'b1;
            r_sm_en   <= w_issue;
            r_sm_rot  <= w_rot;
            r_row_idx <= r_row;
            r_col_idx <= r_col;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_state    <= READ;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_busy     <= 1'b1;
                        r_complete <= 1'b0;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row) r_state <= DRAIN;
                            else            r_row   <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    r_state    <= DONE;
                    r_busy     <= 1'b0;
                    r_complete <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BRAM_WINDOW_SCHED_STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_start_ok) begin
            r_stall <= '0;
        end else if ((r_state == READ) && !out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

    assign busy      = r_busy;
    assign complete  = r_complete;
    assign bram_en   = w_issue;
    assign bram_addr = w_addr;
    assign sm_en     = r_sm_en;
    assign sm_rot    = r_sm_rot;
    assign row_idx   = r_row_idx;
    assign col_idx   = r_col_idx;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bram_window_sched.sv
// Scoreboard bench for bram_window_sched: start pulses push every expected window of a frame,
// a negedge monitor pops and compares each sm_en against a row/bank arithmetic model.
module tb_bram_window_sched;
    import bram_window_pkg::*;

    localparam int COLS  = 4;
    localparam int ROWS  = 12;
    localparam int AW    = min_aw(ROWS, COLS);
    localparam int RW    = idx_w(ROWS);
    localparam int CW    = idx_w(COLS);
    localparam int TOTAL = (ROWS - 4) * COLS;
    localparam int W     = RW + CW + ROT_W + NBANK * AW;

    logic                CLK;
    logic                rst_n;
    logic                start;
    logic                out_ready;
    logic                busy;
    logic                complete;
    logic                bram_en;
    logic [NBANK*AW-1:0] bram_addr;
    logic                sm_en;
    logic [ROT_W-1:0]    sm_rot;
    logic [RW-1:0]       row_idx;
    logic [CW-1:0]       col_idx;
    logic [1:0]          dbg_state;
`ifdef BRAM_WINDOW_SCHED_STALL_CNT_EN
    logic [31:0]         stall_cycles;
`endif

    bram_window_sched #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .start        (start),
        .out_ready    (out_ready),
        .busy         (busy),
        .complete     (complete),
        .bram_en      (bram_en),
        .bram_addr    (bram_addr),
        .sm_en        (sm_en),
        .sm_rot       (sm_rot),
        .row_idx      (row_idx),
        .col_idx      (col_idx),
`ifdef BRAM_WINDOW_SCHED_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int vectors = 0;
    int miscompares = 0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         model_read;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Window (r,c): bank k holds whichever of rows r..r+4 is congruent to k mod 5, at line row/5.
    function automatic logic [W-1:0] exp_window(input int r, input int c);
        logic [NBANK*AW-1:0] a;
        int y;
        a = '0;
        for (int k = 0; k < NBANK; k++) begin
            y = r + ((k - (r % 5)) + 5) % 5;
            a[k*AW +: AW] = AW'((y / 5) * COLS + c);
        end
        return {RW'(r), CW'(c), ROT_W'(r % 5), a};
    endfunction

    logic                prev_en;
    logic [NBANK*AW-1:0] prev_addr;
    logic                done_next;
    logic [W-1:0]        mon_e;

    always @(negedge CLK) begin
        if (!rst_n) begin
            prev_en   = 1'b0;
            prev_addr = '0;
            done_next = 1'b0;
        end else begin
            check("bram_en", 64'(bram_en), 64'(model_read & out_ready));
            check("sm_en_latency", 64'(sm_en), 64'(prev_en));
            if (sm_en) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sm_en_extra: got unexpected window r=%0d c=%0d, required none", row_idx, col_idx);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("window", 64'({row_idx, col_idx, sm_rot, prev_addr}), 64'(mon_e));
                    check("busy_in_frame", 64'({busy, complete}), 64'(2'b10));
                    if (exp_q.size() == 0) done_next = 1'b1;
                end
            end else if (done_next) begin
                check("complete_after_last", 64'({busy, complete}), 64'(2'b01));
                done_next = 1'b0;
            end
            prev_en   = bram_en;
            prev_addr = bram_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_busy_complete"}, 64'({busy, complete}), 64'd0);
        check({tag, "_bram"}, 64'({bram_en, bram_addr}), 64'd0);
        check({tag, "_steer"}, 64'({sm_en, sm_rot, row_idx, col_idx}), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
`ifdef BRAM_WINDOW_SCHED_STALL_CNT_EN
        check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd0);
`endif
    endtask

    task automatic push_frame();
        for (int r = 0; r <= ROWS - 5; r++)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back(exp_window(r, c));
    endtask

    // fix_start/fix_len: deterministic out_ready-low burst; rand_pct: random stall probability.
    task automatic run_frame(input int fix_start, input int fix_len, input int rand_pct,
                             input bit poke_busy, output int stalls);
        int issued;
        int it;
        int n;
        @(posedge CLK); #1;
        start      = 1'b1;
        out_ready  = 1'($urandom_range(1));
        model_read = 1'b0;
        push_frame();
        @(posedge CLK); #1;
        start = 1'b0;
`ifdef BRAM_WINDOW_SCHED_STALL_CNT_EN
        check("stall_clear_on_start", 64'(stall_cycles), 64'd0);
`endif
        issued = 0;
        stalls = 0;
        it     = 0;
        while (issued < TOTAL) begin
            if (it >= fix_start && it < fix_start + fix_len) out_ready = 1'b0;
            else if (rand_pct > 0) out_ready = ($urandom_range(99) >= rand_pct);
            else out_ready = 1'b1;
            start      = poke_busy && (it == 2);
            model_read = 1'b1;
            if (out_ready) issued++;
            else stalls++;
            @(posedge CLK); #1;
            it++;
        end
        model_read = 1'b0;
        start      = 1'b0;
        out_ready  = 1'($urandom_range(1));
        n = 0;
        while (!complete && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        check("complete_seen", 64'(complete), 64'd1);
        check("state_done", 64'(dbg_state), 64'(DONE));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef BRAM_WINDOW_SCHED_STALL_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'(stalls));
        out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("stall_hold_done", 64'(stall_cycles), 64'(stalls));
`endif
    endtask

    task automatic run_abort();
        @(posedge CLK); #1;
        start      = 1'b1;
        out_ready  = 1'b1;
        push_frame();
        @(posedge CLK); #1;
        start      = 1'b0;
        model_read = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_frame");
        exp_q.delete();
        model_read = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (2) @(posedge CLK);
    endtask

    // ---------------- main sequence ----------------
    int st;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b0;
        model_read = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");

        start = 1'b1;
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        @(posedge CLK); #1;
        check("start_at_reset_release", 64'({busy, dbg_state}), 64'({1'b0, IDLE}));

        run_frame(0, 0, 0, 1'b0, st);
        run_frame(5, 3, 0, 1'b1, st);
        run_abort();
        run_frame(0, 0, 0, 1'b0, st);
        run_frame(9, 5, 0, 1'b0, st);
        for (int i = 0; i < 4; i++) begin
            run_frame(0, 0, $urandom_range(50, 10), 1'($urandom_range(1)), st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
